comm_hub_axis: RTL and testbench
================================

// Module: comm_hub_axis
// PURPOSE
//   Parametrised hub between a processor AXI-Stream link and the local PUF datapath bus.
//   Receives and sends BEATS-beat frames into/from a shift buffer of AXI_W*BEATS bits.
//   Exposes the buffer to local blocks as a narrow (AXI_W) shift port and a wide (WIDE_W) parallel port.
//   One instance per system; all internal engines (matrix, index, b-vector) attach here.
// PARAMETERS
//   AXI_W        128  stream and narrow local word width, bits
//   BEATS        4    beats per frame; buffer width BUF_W = AXI_W*BEATS; 1..16
//   WIDE_W       450  wide port width; WIDE_W <= BUF_W, MSB-aligned in buffer
//   BACKOFF_CYC  63   idle cycles after reset / after each completed send before AXI handshakes enable
// PORTS
//   clk              in   1       clock, all logic on rising edge
//   reset            in   1       synchronous, active-high reset
//   op_mode          in   2       00 AXI_REC, 01 AXI_SEN, 10 LOC_RD, 11 LOC_WR
//   data_in_TDATA    in   AXI_W   inbound stream data
//   data_in_TVALID   in   1       inbound valid
//   data_in_TREADY   out  1       inbound ready (registered)
//   data_in_TLAST    in   1       inbound end of frame
//   data_out_TDATA   out  AXI_W   outbound data = buf[BUF_W-1 -: AXI_W]
//   data_out_TVALID  out  1       outbound valid (registered)
//   data_out_TREADY  in   1       outbound ready
//   data_out_TLAST   out  1       outbound end of frame (registered)
//   read_en          in   1       narrow read: shift buffer left one word, zero-fill
//   read_data        out  AXI_W   buf[BUF_W-1 -: AXI_W], combinational
//   read2_data       out  WIDE_W  buf[BUF_W-1 -: WIDE_W], combinational
//   write_en         in   1       narrow write: shift left, write_data into LSB word
//   write_data       in   AXI_W   narrow write data
//   write2_en        in   1       wide write: buf <= {write2_data, (BUF_W-WIDE_W)'0}
//   write2_data      in   WIDE_W  wide write data
//   data_received    out  1       sticky frame-received flag
//   data_sent        out  1       sticky frame-sent flag
// BEHAVIOUR
//   Reset: buf, beat_cnt, all registered outputs = 0; backoff counter reloads to BACKOFF_CYC.
//   axi_en = (backoff counter == 0); counter decrements every cycle until 0; reloads the cycle after a
//     send completes. Local ops (LOC_RD/LOC_WR) ignore axi_en.
//   op_mode change (differs from previous cycle): beat_cnt, data_received, data_sent, TREADY, TVALID,
//     TLAST cleared that cycle; buffer kept. Aborted send drops TVALID - defined abort, no AXI recovery.
//   AXI_REC: TREADY = axi_en & beat_cnt<BEATS & !data_received. Handshake (TVALID&TREADY) shifts
//     TDATA into LSB word, beat_cnt++. data_received set the cycle after a handshake with TLAST=1 or
//     with beat_cnt reaching BEATS; then TREADY held 0. Short frame (TLAST early) leaves data right-aligned.
//   AXI_SEN: TVALID rises one cycle after entry when axi_en & !data_sent; stays high until handshake
//     (never drops on TREADY=0). Each handshake shifts buffer left one word, zero-fill, beat_cnt++.
//     TLAST high exactly while beat_cnt==BEATS-1 and TVALID. After last handshake TVALID/TLAST=0,
//     data_sent=1 next cycle, backoff reloads.
//   LOC_RD: read_en shifts; read_data/read2_data always reflect current buffer (zero latency).
//   LOC_WR: write_en has priority over write2_en when both high; both take effect on the same edge.
//   Enables outside their op_mode are ignored. beat_cnt width $clog2(BEATS+1); never wraps.
// CONFIGURATION
//   COMM_HUB_PROTO_CHK_EN defined: adds output proto_err (1 bit, sticky, reset 0, cleared on op_mode
//     change): set if in AXI_REC TLAST arrives before beat BEATS, or TVALID held after data_received.
//   Undefined: port and logic absent; identical behaviour otherwise.
// TESTING
//   Reset, wait 62 cycles -> TREADY=0; cycle 64 onward in AXI_REC with TVALID=1 -> TREADY=1.
//   AXI_REC 4 beats A,B,C,D, TLAST on D -> buf={A,B,C,D}, data_received=1, TREADY=0 thereafter.
//   AXI_SEN with TREADY toggling 1,0,1,... -> 4 beats out in order A..D, TVALID stable when stalled,
//     TLAST only on D, data_sent=1, next send waits 63 cycles.
//   LOC_WR write2_data=450'h1 -> read2_data=450'h1, buf[61:0]=0; write_en&write2_en -> narrow wins.
//   op_mode 01->10 mid-frame after 2 beats -> TVALID=0, beat_cnt=0, data_sent=0 next cycle.
//   PROTO_CHK_EN: TLAST on beat 2 -> proto_err=1, data_received=1; op_mode change -> proto_err=0.

Source files
------------

// File: rtl/comm_hub_axis.sv
// -----------------------------------------------------------------------------
// comm_hub_axis
//   Hub between the processor AXI-Stream link and the local PUF datapath bus.
//   Inbound frames of BEATS words are shifted into a BUF_W = AXI_W*BEATS bit
//   buffer, and outbound frames are shifted out of it. Local engines reach the
//   same buffer through a narrow (AXI_W) shift port and a wide (WIDE_W)
//   MSB-aligned parallel port.
//
//   Optional feature macro: COMM_HUB_PROTO_CHK_EN
//     defined   -> adds the sticky proto_err output (inbound protocol checker)
//     undefined -> port and checker logic are absent
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   op_mode               00 AXI_REC, 01 AXI_SEN, 10 LOC_RD, 11 LOC_WR
//   data_in_T*            inbound AXI-Stream slave (TREADY registered)
//   data_out_T*           outbound AXI-Stream master (TVALID/TLAST registered)
//   read_en / read_data   narrow read: top word, shift left with zero fill
//   read2_data            wide view of the top WIDE_W buffer bits
//   write_en/write_data   narrow write: shift left, new word into LSB word
//   write2_en/write2_data wide write: top WIDE_W bits loaded, rest zeroed
//   data_received         sticky: inbound frame complete
//   data_sent             sticky: outbound frame complete
//   proto_err             (optional) sticky inbound protocol violation
// -----------------------------------------------------------------------------
module comm_hub_axis #(
  parameter int AXI_W       = 128,
  parameter int BEATS       = 4,
  parameter int WIDE_W      = 450,
  parameter int BACKOFF_CYC = 63
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef COMM_HUB_PROTO_CHK_EN
  output logic                 proto_err,
`endif
  input  logic [1:0]           op_mode,
  input  logic [AXI_W-1:0]     data_in_TDATA,
  input  logic                 data_in_TVALID,
  output logic                 data_in_TREADY,
  input  logic                 data_in_TLAST,
  output logic [AXI_W-1:0]     data_out_TDATA,
  output logic                 data_out_TVALID,
  input  logic                 data_out_TREADY,
  output logic                 data_out_TLAST,
  input  logic                 read_en,
  output logic [AXI_W-1:0]     read_data,
  output logic [WIDE_W-1:0]    read2_data,
  input  logic                 write_en,
  input  logic [AXI_W-1:0]     write_data,
  input  logic                 write2_en,
  input  logic [WIDE_W-1:0]    write2_data,
  output logic                 data_received,
  output logic                 data_sent
);

  localparam int BUF_W = AXI_W * BEATS;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int BO_W  = (BACKOFF_CYC > 0) ? $clog2(BACKOFF_CYC + 1) : 1;

  localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(BEATS - 1);
  localparam logic [BO_W-1:0]  BACKOFF_C = BO_W'(BACKOFF_CYC);

  localparam logic [1:0] MODE_REC = 2'b00;
  localparam logic [1:0] MODE_SEN = 2'b01;
  localparam logic [1:0] MODE_RD  = 2'b10;
  localparam logic [1:0] MODE_WR  = 2'b11;

  logic [BUF_W-1:0] buf_q,      buf_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BO_W-1:0]  backoff_q,  backoff_d;
  logic [1:0]       mode_q;
  logic             tready_q,   tready_d;
  logic             tvalid_q,   tvalid_d;
  logic             tlast_q,    tlast_d;
  logic             rx_done_q,  rx_done_d;
  logic             tx_done_q,  tx_done_d;

  logic mode_chg;
  logic axi_en;

  // A mode change is a one-cycle abort of whatever transfer was in flight.
  assign mode_chg = (op_mode != mode_q);
  assign axi_en   = (backoff_q == '0);

`ifdef COMM_HUB_PROTO_CHK_EN
  logic proto_err_q, proto_err_d;
  assign proto_err = proto_err_q;
`else
  // Protocol checker not built in this configuration.
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    buf_d      = buf_q;
    beat_cnt_d = beat_cnt_q;
    rx_done_d  = rx_done_q;
    tx_done_d  = tx_done_q;
    tready_d   = 1'b0;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    backoff_d  = axi_en ? backoff_q : backoff_q - BO_W'(1);
`ifdef COMM_HUB_PROTO_CHK_EN
    proto_err_d = proto_err_q;
`endif

    if (mode_chg) begin
      // Buffer is kept; only transfer state is dropped.
      beat_cnt_d = '0;
      rx_done_d  = 1'b0;
      tx_done_d  = 1'b0;
`ifdef COMM_HUB_PROTO_CHK_EN
      proto_err_d = 1'b0;
`endif
    end else begin
      unique case (op_mode)
        MODE_REC: begin
          // tready_q is only ever raised in a stable REC cycle, so it alone
          // qualifies the handshake.
          if (tready_q && data_in_TVALID) begin
            buf_d      = (buf_q << AXI_W) | BUF_W'(data_in_TDATA);
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (data_in_TLAST || beat_cnt_d == BEATS_C) rx_done_d = 1'b1;
`ifdef COMM_HUB_PROTO_CHK_EN
            if (data_in_TLAST && beat_cnt_d < BEATS_C) proto_err_d = 1'b1;
`endif
          end
`ifdef COMM_HUB_PROTO_CHK_EN
          if (rx_done_q && data_in_TVALID) proto_err_d = 1'b1;
`endif
          // Look at next-state count/flag so TREADY drops right after the
          // final beat and a surplus beat can never be accepted.
          tready_d = axi_en && (beat_cnt_d < BEATS_C) && !rx_done_d;
        end

        MODE_SEN: begin
          if (tvalid_q) begin
            if (data_out_TREADY) begin
              buf_d      = buf_q << AXI_W;
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
              if (beat_cnt_q == LAST_C) begin
                tx_done_d = 1'b1;
                backoff_d = BACKOFF_C;
              end else begin
                tvalid_d = 1'b1;
              end
            end else begin
              // Stalled beat: TVALID must never retract while waiting.
              tvalid_d = 1'b1;
            end
          end else begin
            tvalid_d = axi_en && !tx_done_q && (beat_cnt_q < BEATS_C);
          end
          tlast_d = tvalid_d && (beat_cnt_d == LAST_C);
        end

        MODE_RD: begin
          if (read_en) buf_d = buf_q << AXI_W;
        end

        MODE_WR: begin
          // Narrow write wins when both strobes are high.
          if (write_en) begin
            buf_d = (buf_q << AXI_W) | BUF_W'(write_data);
          end else if (write2_en) begin
            buf_d = BUF_W'(write2_data) << (BUF_W - WIDE_W);
          end
        end

        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values computed in the previous cycle regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q      <= '0;
      beat_cnt_q <= '0;
      backoff_q  <= BACKOFF_C;
      // Track the mode through reset so leaving reset is not seen as a change.
      mode_q     <= op_mode;
      tready_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      rx_done_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef COMM_HUB_PROTO_CHK_EN
      proto_err_q <= 1'b0;
`endif
    end else begin
      buf_q      <= buf_d;
      beat_cnt_q <= beat_cnt_d;
      backoff_q  <= backoff_d;
      mode_q     <= op_mode;
      tready_q   <= tready_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      rx_done_q  <= rx_done_d;
      tx_done_q  <= tx_done_d;
`ifdef COMM_HUB_PROTO_CHK_EN
      proto_err_q <= proto_err_d;
`endif
    end
  end

  assign data_in_TREADY  = tready_q;
  assign data_out_TVALID = tvalid_q;
  assign data_out_TLAST  = tlast_q;
  assign data_out_TDATA  = buf_q[BUF_W-1 -: AXI_W];
  assign read_data       = buf_q[BUF_W-1 -: AXI_W];
  assign read2_data      = buf_q[BUF_W-1 -: WIDE_W];
  assign data_received   = rx_done_q;
  assign data_sent       = tx_done_q;

endmodule

// File: tb/tb_comm_hub_axis.sv
// -----------------------------------------------------------------------------
// tb_comm_hub_axis
//   Self-checking bench for comm_hub_axis (default parameters). The reference
//   model keeps the buffer as a queue of BEATS words, top word first.
// -----------------------------------------------------------------------------
module tb_comm_hub_axis;

  localparam int AXI_W  = 128;
  localparam int BEATS  = 4;
  localparam int WIDE_W = 450;
  localparam int BUF_W  = AXI_W * BEATS;

  localparam logic [1:0] REC = 2'b00;
  localparam logic [1:0] SEN = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] WR  = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        op_mode;
  logic [AXI_W-1:0]  data_in_TDATA;
  logic              data_in_TVALID;
  logic              data_in_TREADY;
  logic              data_in_TLAST;
  logic [AXI_W-1:0]  data_out_TDATA;
  logic              data_out_TVALID;
  logic              data_out_TREADY;
  logic              data_out_TLAST;
  logic              read_en;
  logic [AXI_W-1:0]  read_data;
  logic [WIDE_W-1:0] read2_data;
  logic              write_en;
  logic [AXI_W-1:0]  write_data;
  logic              write2_en;
  logic [WIDE_W-1:0] write2_data;
  logic              data_received;
  logic              data_sent;
`ifdef COMM_HUB_PROTO_CHK_EN
  logic              proto_err;
`endif

  comm_hub_axis #(
    .AXI_W(AXI_W), .BEATS(BEATS), .WIDE_W(WIDE_W), .BACKOFF_CYC(63)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef COMM_HUB_PROTO_CHK_EN
    .proto_err(proto_err),
`endif
    .op_mode(op_mode),
    .data_in_TDATA(data_in_TDATA),
    .data_in_TVALID(data_in_TVALID),
    .data_in_TREADY(data_in_TREADY),
    .data_in_TLAST(data_in_TLAST),
    .data_out_TDATA(data_out_TDATA),
    .data_out_TVALID(data_out_TVALID),
    .data_out_TREADY(data_out_TREADY),
    .data_out_TLAST(data_out_TLAST),
    .read_en(read_en),
    .read_data(read_data),
    .read2_data(read2_data),
    .write_en(write_en),
    .write_data(write_data),
    .write2_en(write2_en),
    .write2_data(write2_data),
    .data_received(data_received),
    .data_sent(data_sent)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: buffer as a queue of words ------------
  logic [AXI_W-1:0] mq [$];

  function automatic logic [BUF_W-1:0] mflat();
    logic [BUF_W-1:0] r;
    r = '0;
    for (int i = 0; i < BEATS; i++) r[BUF_W-1-AXI_W*i -: AXI_W] = mq[i];
    return r;
  endfunction

  task automatic m_shift(input logic [AXI_W-1:0] fill);
    void'(mq.pop_front());
    mq.push_back(fill);
  endtask

  task automatic m_load_wide(input logic [WIDE_W-1:0] w);
    logic [BUF_W-1:0] f;
    f = {w, {(BUF_W-WIDE_W){1'b0}}};
    for (int i = 0; i < BEATS; i++) mq[i] = f[BUF_W-1-AXI_W*i -: AXI_W];
  endtask

  task automatic check_buf(input string name);
    logic [BUF_W-1:0] f;
    f = mflat();
    check({name, "_rd"},  read_data,  f[BUF_W-1 -: AXI_W]);
    check({name, "_rd2"}, read2_data, f[BUF_W-1 -: WIDE_W]);
  endtask

  function automatic logic [AXI_W-1:0] rand128();
    logic [AXI_W-1:0] t;
    for (int k = 0; k < 4; k++) t[32*k +: 32] = $urandom;
    return t;
  endfunction

  function automatic logic [WIDE_W-1:0] rand450();
    logic [479:0] t;
    for (int k = 0; k < 15; k++) t[32*k +: 32] = $urandom;
    return t[WIDE_W-1:0];
  endfunction

  // Present one inbound beat after 'gap' idle cycles; wait (bounded) for it
  // to be accepted.
  task automatic rec_beat(input logic [AXI_W-1:0] d, input logic last, input int gap);
    logic hs;
    logic ok;
    data_in_TVALID = 1'b0;
    repeat (gap) tick();
    data_in_TDATA  = d;
    data_in_TLAST  = last;
    data_in_TVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hs = data_in_TREADY;
      tick();
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    data_in_TVALID = 1'b0;
    data_in_TLAST  = 1'b0;
    check("rec_beat_accepted", ok, 1'b1);
  endtask

  // ---------------- table of local-port vectors ----------------------------
  typedef struct {
    logic [1:0]        op;
    logic              we;
    logic [AXI_W-1:0]  wd;
    logic              w2e;
    logic [WIDE_W-1:0] w2d;
    logic              re;
    logic [AXI_W-1:0]  exp_rd;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [1:0] op, input logic we, input logic [AXI_W-1:0] wd,
                              input logic w2e, input logic [WIDE_W-1:0] w2d, input logic re,
                              input logic [AXI_W-1:0] exp_rd);
    vec_t v;
    v.op = op; v.we = we; v.wd = wd; v.w2e = w2e; v.w2d = w2d; v.re = re; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic apply_row(input int i);
    op_mode     = tbl[i].op;
    write_en    = tbl[i].we;
    write_data  = tbl[i].wd;
    write2_en   = tbl[i].w2e;
    write2_data = tbl[i].w2d;
    read_en     = tbl[i].re;
    tick();
    check($sformatf("table_row%0d", i), read_data, tbl[i].exp_rd);
    write_en = 1'b0; write2_en = 1'b0; read_en = 1'b0;
  endtask

  localparam logic [AXI_W-1:0] W_A = 128'hA0A0_0001_A0A0_0002_A0A0_0003_A0A0_0004;
  localparam logic [AXI_W-1:0] W_B = 128'hB0B0_0011_B0B0_0012_B0B0_0013_B0B0_0014;
  localparam logic [AXI_W-1:0] W_C = 128'hC0C0_0021_C0C0_0022_C0C0_0023_C0C0_0024;
  localparam logic [AXI_W-1:0] W_D = 128'hD0D0_0031_D0D0_0032_D0D0_0033_D0D0_0034;
  localparam logic [AXI_W-1:0] W_E = 128'hE0E0_0041_E0E0_0042_E0E0_0043_E0E0_0044;
  localparam logic [AXI_W-1:0] ONES = '1;
  localparam logic [AXI_W-1:0] W0_ONES = 128'hFFFF_FFFF_FFFF_FFFF_C000_0000_0000_0000;
  localparam logic [AXI_W-1:0] BIT62   = 128'h0000_0000_0000_0000_4000_0000_0000_0000;
  localparam logic [WIDE_W-1:0] WIDE_ONE  = 450'h1;
  localparam logic [WIDE_W-1:0] WIDE_ONES = '1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AXI_W-1:0] exp_words [4];
    logic [AXI_W-1:0] sent_d [4];
    logic             sent_l [4];
    logic [AXI_W-1:0] new_words [4];
    logic [AXI_W-1:0] d;
    logic             v, l, rdy;
    logic [1:0]       prev_op, op;
    int               got, len;

    reset = 1'b1; op_mode = REC;
    data_in_TDATA = '0; data_in_TVALID = 1'b0; data_in_TLAST = 1'b0;
    data_out_TREADY = 1'b0;
    read_en = 1'b0; write_en = 1'b0; write_data = '0;
    write2_en = 1'b0; write2_data = '0;
    for (int i = 0; i < BEATS; i++) mq.push_back('0);

    repeat (3) tick();
    reset = 1'b0;

    // ---- reset state ----
    check("rst_tready",   data_in_TREADY, 0);
    check("rst_tvalid",   data_out_TVALID, 0);
    check("rst_tlast",    data_out_TLAST, 0);
    check("rst_received", data_received, 0);
    check("rst_sent",     data_sent, 0);
    check_buf("rst_buf");

    // ---- backoff after reset: TREADY first high after the 64th edge ----
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 1 || k == 62 || k == 63) check($sformatf("backoff_tready_c%0d", k), data_in_TREADY, 0);
      if (k == 64) check("backoff_tready_c64", data_in_TREADY, 1);
    end

    // ---- AXI_REC full frame A,B,C,D ----
    exp_words = '{W_A, W_B, W_C, W_D};
    for (int b = 0; b < 4; b++) begin
      rec_beat(exp_words[b], b == 3, 0);
      m_shift(exp_words[b]);
      if (b < 3) check("rec_not_done_early", data_received, 0);
    end
    check("rec_received", data_received, 1);
    check("rec_top_word", data_out_TDATA, W_A);
    check_buf("rec_abcd");
    repeat (3) tick();
    check("rec_tready_held_low", data_in_TREADY, 0);

    // ---- AXI_SEN with TREADY toggling ----
    op_mode = SEN;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      rdy = (cyc % 2 == 0);
      data_out_TREADY = rdy;
      v = data_out_TVALID; d = data_out_TDATA; l = data_out_TLAST;
      tick();
      if (v && rdy) begin
        sent_d[got] = d; sent_l[got] = l; got++;
      end else if (v) begin
        check("sen_stall_valid", data_out_TVALID, 1);
        check("sen_stall_data",  data_out_TDATA, d);
      end
    end
    data_out_TREADY = 1'b0;
    check("sen_beat_count", got, 4);
    for (int i = 0; i < got; i++) begin
      check($sformatf("sen_word%0d", i), sent_d[i], exp_words[i]);
      check($sformatf("sen_tlast%0d", i), sent_l[i], i == 3);
    end
    for (int i = 0; i < 4; i++) m_shift('0);
    check("sen_done_tvalid", data_out_TVALID, 0);
    check("sen_done_tlast",  data_out_TLAST, 0);
    check("sen_data_sent",   data_sent, 1);

    // ---- refill, re-enter SEN, measure backoff, then abort after 2 beats ----
    // Edge of the final handshake is t=0.
    new_words = '{rand128(), rand128(), rand128(), rand128()};
    op_mode = WR; tick();                            // t=1, mode change
    for (int k = 0; k < 4; k++) begin                // t=2..5
      write_en = 1'b1; write_data = new_words[k];
      tick();
      m_shift(new_words[k]);
    end
    write_en = 1'b0;
    op_mode = SEN; tick();                           // t=6, mode change
    repeat (57) tick();                              // t=63
    check("resend_tvalid_t63", data_out_TVALID, 0);
    tick();                                          // t=64
    check("resend_tvalid_t64", data_out_TVALID, 1);
    check("resend_first_word", data_out_TDATA, new_words[0]);
    data_out_TREADY = 1'b1;
    tick(); m_shift('0);
    tick(); m_shift('0);
    check("abort_pre_tvalid", data_out_TVALID, 1);
    check("abort_pre_word",   data_out_TDATA, new_words[2]);
    op_mode = RD; data_out_TREADY = 1'b0;
    tick();
    check("abort_tvalid", data_out_TVALID, 0);
    check("abort_tlast",  data_out_TLAST, 0);
    check("abort_sent",   data_sent, 0);
    check_buf("abort_buf_kept");

    // ---- table-driven local port vectors ----
    tbl[0]  = mk(WR, 0, '0,  1, '0,        0, '0);
    tbl[1]  = mk(WR, 1, W_A, 0, '0,        0, '0);
    tbl[2]  = mk(WR, 1, W_B, 0, '0,        0, '0);
    tbl[3]  = mk(WR, 1, W_C, 0, '0,        0, '0);
    tbl[4]  = mk(WR, 1, W_D, 0, '0,        0, W_A);
    tbl[5]  = mk(WR, 1, W_E, 1, WIDE_ONES, 0, W_B);
    tbl[6]  = mk(WR, 0, '0,  1, WIDE_ONES, 0, ONES);
    tbl[7]  = mk(RD, 0, '0,  0, '0,        1, ONES);
    tbl[8]  = mk(RD, 0, '0,  0, '0,        1, ONES);
    tbl[9]  = mk(RD, 0, '0,  0, '0,        1, ONES);
    tbl[10] = mk(RD, 0, '0,  0, '0,        1, W0_ONES);
    tbl[11] = mk(RD, 0, '0,  0, '0,        1, '0);
    tbl[12] = mk(RD, 1, W_A, 1, WIDE_ONES, 0, '0);
    tbl[13] = mk(WR, 0, '0,  1, WIDE_ONE,  0, '0);
    tbl[14] = mk(WR, 0, '0,  1, WIDE_ONE,  0, '0);
    tbl[15] = mk(RD, 0, '0,  0, '0,        1, '0);
    tbl[16] = mk(RD, 0, '0,  0, '0,        1, '0);
    tbl[17] = mk(RD, 0, '0,  0, '0,        1, '0);
    tbl[18] = mk(RD, 0, '0,  0, '0,        1, BIT62);

    op_mode = WR; tick();
    for (int i = 0; i <= 14; i++) apply_row(i);
    check("wide_write_one_rd2", read2_data, WIDE_ONE);
    for (int i = 15; i <= 18; i++) apply_row(i);

    // ---- randomized local traffic vs model ----
    op_mode = WR; tick();
    prev_op = WR;
    op = WR;
    for (int i = 0; i < 200; i++) begin
      if (i > 0 && $urandom_range(0, 9) == 0) op = (op == WR) ? RD : WR;
      op_mode     = op;
      write_en    = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      write2_en   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      read_en     = 1'($urandom_range(0, 1));
      write_data  = rand128();
      write2_data = rand450();
      tick();
      if (op == prev_op) begin
        if (op == RD && read_en)        m_shift('0);
        else if (op == WR && write_en)  m_shift(write_data);
        else if (op == WR && write2_en) m_load_wide(write2_data);
      end
      prev_op = op;
      check_buf("rand_local");
    end
    write_en = 1'b0; write2_en = 1'b0; read_en = 1'b0;

    // ---- randomized inbound frames (short frames stay right-aligned) ----
    for (int f = 0; f < 6; f++) begin
      op_mode = RD; tick();
      op_mode = REC; tick();
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        d = rand128();
        // A full-length frame may omit TLAST; the beat count ends it.
        rec_beat(d, (b == len - 1) && (len < 4 || $urandom_range(0, 1) == 1), $urandom_range(0, 2));
        m_shift(d);
        if (b < len - 1) check("rand_rec_not_done", data_received, 0);
      end
      check("rand_rec_received", data_received, 1);
      tick();
      check("rand_rec_tready_low", data_in_TREADY, 0);
      check_buf("rand_rec_buf");
    end

    // ---- short frame: TLAST on beat 2 ----
    op_mode = RD; tick();
    op_mode = REC; tick();
    rec_beat(W_C, 1'b0, 0);
    rec_beat(W_D, 1'b1, 0);
    m_shift(W_C); m_shift(W_D);
    check("short_received", data_received, 1);
    check_buf("short_buf");
`ifdef COMM_HUB_PROTO_CHK_EN
    check("proto_err_set", proto_err, 1);
`endif
    op_mode = RD; tick();
    check("short_clear_received", data_received, 0);
`ifdef COMM_HUB_PROTO_CHK_EN
    check("proto_err_cleared", proto_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
